wrr_arbiter: RTL

Parametrised weighted round-robin arbiter with registered, held grants and a transfer-acknowledge handshake. Each requester wins a tenure of up to `weight[i]` acknowledged transfers, or an unbounded tenure while it holds `lock[i]`. The pointer then rotates past the winner. It sits in front of shared buses and memory ports where single-cycle grants are not enough and requesters need burst ownership with fair, tunable bandwidth.

---
 rtl/wrr_arbiter.sv | 97 +++++++++
 1 files changed

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter: held one-hot grant per tenure of up to weight[i] acked
// transfers (unbounded while lock[i]); 1-cycle request-to-grant, zero-bubble handoff.
module wrr_arbiter #(
  parameter int N   = 4,
  parameter int WW  = 4,
  parameter int IDW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  input  logic [N-1:0]    lock,
  input  logic [N*WW-1:0] weight,
  input  logic            ack,
  output logic [N-1:0]    grant,
  output logic            grant_valid,
  output logic [IDW-1:0]  grant_id,
  output logic [WW-1:0]   credit_left
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t         state;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] owner;
  logic [WW-1:0]  credit;

  logic [IDW-1:0] nxt_ptr;
  logic [IDW-1:0] scan_base;
  logic [IDW-1:0] sel;
  logic [WW-1:0]  sel_credit;
  logic           tenure_end;

  // First requester at or after p, wrapping modulo N.
  function automatic logic [IDW-1:0] pick(input logic [N-1:0] r, input logic [IDW-1:0] p);
    logic [IDW-1:0] res;
    logic           found;
    int             idx;
    res   = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = int'(p) + k;
      if (idx >= N) idx = idx - N;
      if (!found && r[idx]) begin
        res   = IDW'(idx);
        found = 1'b1;
      end
    end
    return res;
  endfunction

  always_comb begin
    nxt_ptr    = (owner == IDW'(N - 1)) ? '0 : owner + 1'b1;
    scan_base  = (state == IDLE) ? ptr : nxt_ptr;
    sel        = pick(req, scan_base);
    sel_credit = weight[sel*WW +: WW];
    if (sel_credit == '0) sel_credit = WW'(1);
    // A withdrawn request ends the tenure even if ack is high in the same cycle.
    tenure_end = (state == GRANT) &&
                 (!req[owner] || (ack && credit == WW'(1) && !lock[owner]));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      ptr    <= '0;
      owner  <= '0;
      credit <= '0;
      grant  <= '0;
    end else if (state == IDLE) begin
      if (|req) begin
        state  <= GRANT;
        owner  <= sel;
        credit <= sel_credit;
        grant  <= N'(1) << sel;
      end
    end else if (tenure_end) begin
      ptr <= nxt_ptr;
      if (|req) begin
        owner  <= sel;
        credit <= sel_credit;
        grant  <= N'(1) << sel;
      end else begin
        state  <= IDLE;
        owner  <= '0;
        credit <= '0;
        grant  <= '0;
      end
    end else if (ack && credit > WW'(1)) begin
      credit <= credit - 1'b1;
    end
  end

  assign grant_valid = (state == GRANT);
  assign grant_id    = owner;
  assign credit_left = credit;

endmodule
